// File: rtl/des_perm_unit_if.sv
// Config and valid/ready data bundle for des_perm_unit.
// The slave modport is the permutation block's view.
interface des_perm_unit_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32,
    parameter int SRC_W = $clog2(IN_W + 1),
    parameter int SEL_W = $clog2(OUT_W + 1)
);
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_sel;
    logic [SRC_W-1:0] cfg_src;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output cfg_we, cfg_sel, cfg_src, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_src, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_perm_unit.sv
// Table-driven bit select (DES P/E/PC-2 style, 1-based MSB-first positions)
// feeding a single registered valid/ready output stage.
module des_perm_unit #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32,
    parameter int SRC_W = $clog2(IN_W + 1),
    parameter int SEL_W = $clog2(OUT_W + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    des_perm_unit_if.slave bus
);
    localparam logic [SRC_W-1:0] SRC_MAX = SRC_W'(IN_W);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(OUT_W);

    // tbl_q[j] holds the input position feeding output position j+1
    logic [OUT_W-1:0][SRC_W-1:0] tbl_q, tbl_d, tbl_rst;
    logic [OUT_W-1:0]            data_q, data_d, perm;
    logic                        valid_q, valid_d;
    logic                        err_q, err_d;
    logic                        in_ready, fire, cfg_ok;

    assign in_ready = !valid_q || bus.out_ready;
    assign fire     = bus.in_valid && in_ready;
    assign cfg_ok   = (bus.cfg_sel != '0) && (bus.cfg_sel <= SEL_MAX) &&
                      (bus.cfg_src != '0) && (bus.cfg_src <= SRC_MAX);

    for (genvar j = 0; j < OUT_W; j++) begin : g_lane
        logic [IN_W-1:0] hit;

        // hit[k] marks input bit k, i.e. position IN_W-k
        for (genvar k = 0; k < IN_W; k++) begin : g_src
            assign hit[k] = (tbl_q[j] == SRC_W'(IN_W - k));
        end

        assign perm[OUT_W-1-j] = |(hit & bus.in_data);
        assign tbl_rst[j]      = SRC_W'((j % IN_W) + 1);
        assign tbl_d[j]        = (bus.cfg_we && cfg_ok && bus.cfg_sel == SEL_W'(j + 1))
                                 ? bus.cfg_src : tbl_q[j];
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = bus.cfg_we && !cfg_ok;
        if (fire) begin
            valid_d = 1'b1;
            data_d  = perm;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q   <= tbl_rst;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            tbl_q   <= tbl_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: doc/des_perm_unit.md
# des_perm_unit

Runtime-programmable, handshaked bit-permutation/expansion stage for the SPI DES datapath. It generalises the fixed DES P box. The mapping is held in a loadable table, so one block instance can implement P, E (32→48), PC-2 (56→48) or any other selection, for independent input and output widths. It sits between DES round-function stages, with valid/ready flow control on both sides and one registered output stage.

## Interface
Parameters:
- IN_W, 32, input word width in bits (≥2)
- OUT_W, 32, output word width in bits (≥1)
- SRC_W, $clog2(IN_W+1), width of a source-index field (derived)
- SEL_W, $clog2(OUT_W+1), width of an output-position field (derived)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_sel  in  SEL_W  output position to program, 1..OUT_W
- cfg_src  in  SRC_W  source input position, 1..IN_W
- cfg_err  out  1  one-cycle pulse when a write is rejected
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- in_data  in  IN_W  input word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_W  permuted word

## Operation
- Bit numbering follows DES convention: position k (1-based) of a W-bit word is bit [W-k]. Position 1 is the MSB.
- Table: OUT_W entries of SRC_W bits. Entry j gives the input position that drives output position j.
  - Reset contents: entry j = ((j-1) mod IN_W)+1. This is identity when OUT_W=IN_W and wraps when OUT_W>IN_W.
- Table write: when cfg_we=1 and 1≤cfg_sel≤OUT_W and 1≤cfg_src≤IN_W, entry cfg_sel←cfg_src at the clock edge.
  - If either field is out of range (including 0), the write is ignored. cfg_err is 1 in the following cycle.
- Transfer: the input fires when in_valid && in_ready. Each output position j of the registered result takes input position table[j].
- Table updates are not synchronised with data:
  - A word accepted in the same cycle as a table write uses the pre-write table.
  - Words accepted later use the new table.
- Flow control: a single output register, no internal buffering.
  - in_ready = !out_valid || out_ready (combinational).
  - out_valid sets on an input fire.
  - out_valid clears when out_ready=1 and no new input fires in that cycle.
  - Simultaneous output drain and input fire: the register is reloaded and out_valid stays 1, giving full throughput.
- out_data is held stable while out_valid=1 and out_ready=0.
- Output bits are not inverted, and no other transform is applied. Repeated source indices are legal (expansion).

## Timing
- Reset (rst_n=0 at edge), effective the same edge:
  - out_valid=0, out_data=0, cfg_err=0.
  - Table returns to its reset contents.
  - in_ready reads 1 once out_valid=0.
- Reset mid-operation: any held output word is discarded, with no out_valid afterwards. Any table write in that cycle is dropped.
- Latency: 1 cycle, input fire at edge N → out_valid=1 with data after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- Table write → visible to data accepted at edge N+1 and later.
- cfg_err: high for exactly one cycle per rejected write. It is 0 otherwise, and never asserted by a valid write.
- No combinational path from in_data to out_data. in_ready is the only combinational output, from out_valid and out_ready.

## Test plan
- Reset identity, IN_W=OUT_W=32: push 0x12345678 with out_ready=1 → out_data=0x12345678 one cycle later, out_valid high for 1 cycle.
- Load DES P (entry 1=16, 2=7, …, 9=1, …, 32=25), push 0x80000000 → out_data=0x00800000. Push 0x00000001 → out_data=0x00000800 (input 32 → output 21).
- Expansion IN_W=32, OUT_W=48, load DES E, push 0x00000001 → out_data=0x800000000002 (input 32 → outputs 1 and 47).
- Backpressure: out_ready=0 for 5 cycles after first word:
  - in_ready=0 and out_data is stable throughout.
  - Release with in_valid held → words emerge in order, with no drop or duplicate.
- Rejects: cfg_sel=0, cfg_sel=33 and cfg_src=33 each → cfg_err pulses 1 cycle, and a subsequent data word shows the table unchanged.
- Same-cycle write: table write and input fire in one cycle → that word uses the old mapping and the next uses the new one. Then assert rst_n=0 with out_valid=1 → out_valid=0, out_data=0 and identity table restored after the edge.
